// File: rtl/level_pwm_pkg.sv
// Shared types and constants for the level ramp / PWM output stage.
// Used by the channel sub-module and the top.
package level_pwm_pkg;

  localparam int LVL_BITS_DEF = 3;
  localparam int LVL_MAX = (1 << LVL_BITS_DEF) - 1;
  localparam int BAR_W = 7;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/level_ramp_channel.sv
// One slewed level channel: target compare, ramp FSM, current level,
// PWM duty compare and thermometer bargraph.
module level_ramp_channel
  import level_pwm_pkg::*;
#(
  parameter int LVL_BITS = 3,
  parameter int PWM_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_tick,
  input  logic [LVL_BITS-1:0] i_tgt,
  input  logic [PWM_BITS-1:0] i_pc,
  output logic                o_pwm,
  output logic [BAR_W-1:0]    o_bar,
  output logic                o_busy
);

  ramp_state_t               r_state;
  ramp_state_t               w_next;
  logic [LVL_BITS-1:0]       r_cur;
  logic [LVL_BITS-1:0]       w_cur_nxt;
  logic [PWM_BITS-1:0]       w_duty;
  logic [BAR_W-1:0]          w_bar;
  logic                      r_pwm;
  logic [BAR_W-1:0]          r_bar;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HOLD;
      r_cur   <= '0;
      r_pwm   <= 1'b0;
      r_bar   <= '0;
    end else begin
      r_state <= w_next;
      r_cur   <= w_cur_nxt;
      r_pwm   <= (i_pc < w_duty);
      r_bar   <= w_bar;
    end
  end

  always_comb begin
    w_next = HOLD;
    unique case (1'b1)
      (r_cur < i_tgt): w_next = UP;
      (r_cur > i_tgt): w_next = DOWN;
      default:         w_next = HOLD;
    endcase
  end

  // Step from the live compare so a target change never overshoots.
  always_comb begin
    w_cur_nxt = r_cur;
    if (i_tick) begin
      case (w_next)
        UP:      w_cur_nxt = r_cur + LVL_BITS'(1);
        DOWN:    w_cur_nxt = r_cur - LVL_BITS'(1);
        default: w_cur_nxt = r_cur;
      endcase
    end
    w_duty = {r_cur, {(PWM_BITS-LVL_BITS){1'b0}}};
    w_bar = '0;
    for (int i = 0; i < BAR_W; i++) begin
      w_bar[i] = (int'(r_cur) > i);
    end
  end

  assign o_pwm  = r_pwm;
  assign o_bar  = r_bar;
  assign o_busy = (r_state != HOLD);

endmodule

// File: rtl/level_pwm_driver.sv
// Volume/bass output stage: registers FSM levels, applies mute,
// shares one ramp divider and PWM counter across both channels.
module level_pwm_driver
  import level_pwm_pkg::*;
#(
  parameter int LVL_BITS = 3,
  parameter int PWM_BITS = 5,
  parameter int RAMP_DIV = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [LVL_BITS-1:0] vol_lvl,
  input  logic [LVL_BITS-1:0] bass_lvl,
  input  logic                mute,
  output logic                pwm_vol,
  output logic                pwm_bass,
  output logic [BAR_W-1:0]    vol_bar,
  output logic [BAR_W-1:0]    bass_bar,
  output logic                busy
);

  localparam int DW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  logic [LVL_BITS-1:0] r_vol_lvl;
  logic [LVL_BITS-1:0] r_bass_lvl;
  logic                r_mute;
  logic [DW-1:0]       r_div;
  logic [PWM_BITS-1:0] r_pc;
  logic                w_tick;
  logic [LVL_BITS-1:0] w_tgt_vol;
  logic                w_busy_vol;
  logic                w_busy_bass;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vol_lvl  <= '0;
      r_bass_lvl <= '0;
      r_mute     <= 1'b0;
      r_div      <= '0;
      r_pc       <= '0;
    end else begin
      r_vol_lvl  <= vol_lvl;
      r_bass_lvl <= bass_lvl;
      r_mute     <= mute;
      r_div      <= w_tick ? '0 : r_div + DW'(1);
      r_pc       <= r_pc + PWM_BITS'(1);
    end
  end

  assign w_tick    = (r_div == DIV_LAST);
  assign w_tgt_vol = r_mute ? '0 : r_vol_lvl;

  level_ramp_channel #(
    .LVL_BITS(LVL_BITS),
    .PWM_BITS(PWM_BITS)
  ) u_vol (
    .clock  (clock),
    .reset  (reset),
    .i_tick (w_tick),
    .i_tgt  (w_tgt_vol),
    .i_pc   (r_pc),
    .o_pwm  (pwm_vol),
    .o_bar  (vol_bar),
    .o_busy (w_busy_vol)
  );

  level_ramp_channel #(
    .LVL_BITS(LVL_BITS),
    .PWM_BITS(PWM_BITS)
  ) u_bass (
    .clock  (clock),
    .reset  (reset),
    .i_tick (w_tick),
    .i_tgt  (r_bass_lvl),
    .i_pc   (r_pc),
    .o_pwm  (pwm_bass),
    .o_bar  (bass_bar),
    .o_busy (w_busy_bass)
  );

  assign busy = w_busy_vol | w_busy_bass;

endmodule

// File: tb/tb_level_pwm_driver.sv
// Scoreboard bench for level_pwm_driver: expected bargraph steps are
// queued with each stimulus and popped as the outputs change.
module tb_level_pwm_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] vol_lvl;
  logic [2:0] bass_lvl;
  logic       mute;
  logic       pwm_vol;
  logic       pwm_bass;
  logic [6:0] vol_bar;
  logic [6:0] bass_bar;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int q_vol[$];
  int q_bass[$];
  int q_vt[$];
  bit mon_en = 0;
  bit rec = 0;
  int n_vchg = 0;
  logic [6:0] p_vol = '0;
  logic [6:0] p_bass = '0;
  logic [6:0] vmax = '0;

  level_pwm_driver #(
    .LVL_BITS(3),
    .PWM_BITS(5),
    .RAMP_DIV(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .vol_lvl  (vol_lvl),
    .bass_lvl (bass_lvl),
    .mute     (mute),
    .pwm_vol  (pwm_vol),
    .pwm_bass (pwm_bass),
    .vol_bar  (vol_bar),
    .bass_bar (bass_bar),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int therm(input int lvl);
    return (1 << lvl) - 1;
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (mon_en) begin
      if (vol_bar !== p_vol) begin
        n_vchg++;
        if (rec) q_vt.push_back(cyc);
        if (vol_bar > vmax) vmax = vol_bar;
        if (q_vol.size() == 0) chk("vol_unexp", int'(vol_bar), int'(p_vol));
        else chk("vol_step", int'(vol_bar), therm(q_vol.pop_front()));
      end
      if (bass_bar !== p_bass) begin
        if (q_bass.size() == 0) chk("bass_unexp", int'(bass_bar), int'(p_bass));
        else chk("bass_step", int'(bass_bar), therm(q_bass.pop_front()));
      end
    end
    p_vol = vol_bar;
    p_bass = bass_bar;
  end

  task automatic settle(input string tag);
    int n = 0;
    @(negedge clock);
    while ((q_vol.size() != 0 || q_bass.size() != 0 || busy) && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk(tag, int'(n < 400), 1);
  endtask

  task automatic count_hi(output int nv, output int nb);
    nv = 0;
    nb = 0;
    repeat (32) begin
      @(negedge clock);
      nv += int'(pwm_vol);
      nb += int'(pwm_bass);
    end
  endtask

  task automatic wait_vbar(input logic [6:0] v);
    int n = 0;
    while (vol_bar !== v && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("wait_vbar", int'(n < 200), 1);
  endtask

  initial begin
    int nv, nb, n0;
    reset = 1'b1;
    vol_lvl = 3'd5;
    bass_lvl = 3'd0;
    mute = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_vbar", int'(vol_bar), 0);
    chk("rst_bbar", int'(bass_bar), 0);
    chk("rst_pwmv", int'(pwm_vol), 0);
    chk("rst_pwmb", int'(pwm_bass), 0);
    chk("rst_busy", int'(busy), 0);
    vol_lvl = 3'd0;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("idle_vbar", int'(vol_bar), 0);
    chk("idle_busy", int'(busy), 0);
    mon_en = 1;

    rec = 1;
    for (int i = 1; i <= 5; i++) q_vol.push_back(i);
    vol_lvl = 3'd5;
    settle("t2_settle");
    rec = 0;
    chk("t2_nsteps", q_vt.size(), 5);
    for (int i = 1; i < q_vt.size(); i++)
      chk("t2_gap", q_vt[i] - q_vt[i-1], 4);
    chk("t2_vbar", int'(vol_bar), 'h1F);
    chk("t2_busy", int'(busy), 0);
    count_hi(nv, nb);
    chk("t2_pwm20", nv, 20);

    for (int i = 4; i >= 0; i--) q_vol.push_back(i);
    vol_lvl = 3'd0;
    settle("t3_down");
    vmax = '0;
    for (int i = 1; i <= 3; i++) q_vol.push_back(i);
    vol_lvl = 3'd7;
    wait_vbar(7'h07);
    @(negedge clock);
    q_vol.push_back(2);
    q_vol.push_back(1);
    vol_lvl = 3'd1;
    settle("t3_settle");
    chk("t3_vbar", int'(vol_bar), 'h01);
    chk("t3_vmax", int'(vmax), 'h07);

    for (int i = 2; i <= 6; i++) q_vol.push_back(i);
    for (int i = 1; i <= 4; i++) q_bass.push_back(i);
    vol_lvl = 3'd6;
    bass_lvl = 3'd4;
    settle("t4_up");
    chk("t4_bbar", int'(bass_bar), 'h0F);
    n0 = n_vchg;
    for (int i = 5; i >= 0; i--) q_vol.push_back(i);
    mute = 1'b1;
    settle("t4_mute");
    chk("t4_mticks", n_vchg - n0, 6);
    chk("t4_mvbar", int'(vol_bar), 0);
    chk("t4_mbbar", int'(bass_bar), 'h0F);
    for (int i = 1; i <= 6; i++) q_vol.push_back(i);
    mute = 1'b0;
    settle("t4_unmute");
    chk("t4_uvbar", int'(vol_bar), 'h3F);
    chk("t4_ubbar", int'(bass_bar), 'h0F);

    q_vol.push_back(7);
    for (int i = 3; i >= 0; i--) q_bass.push_back(i);
    vol_lvl = 3'd7;
    bass_lvl = 3'd0;
    settle("t5_settle");
    chk("t5_vbar", int'(vol_bar), 'h7F);
    count_hi(nv, nb);
    chk("t5_pwmv_a", nv, 28);
    chk("t5_pwmb_a", nb, 0);
    count_hi(nv, nb);
    chk("t5_pwmv_b", nv, 28);
    chk("t5_pwmb_b", nb, 0);

    for (int i = 6; i >= 0; i--) q_vol.push_back(i);
    vol_lvl = 3'd0;
    settle("t6_down");
    for (int i = 1; i <= 3; i++) q_vol.push_back(i);
    vol_lvl = 3'd7;
    wait_vbar(7'h07);
    @(negedge clock);
    chk("t6_busy_pre", int'(busy), 1);
    q_vol.delete();
    q_vol.push_back(0);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_vbar", int'(vol_bar), 0);
    chk("t6_pwmv", int'(pwm_vol), 0);
    chk("t6_busy", int'(busy), 0);
    for (int i = 1; i <= 7; i++) q_vol.push_back(i);
    reset = 1'b0;
    settle("t6_settle");
    chk("t6_vbar_end", int'(vol_bar), 'h7F);

    chk("q_vol_empty", q_vol.size(), 0);
    chk("q_bass_empty", q_bass.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
